// File: rtl/smpl_capture_if.sv
// Sample-stream bundle between the ADC front end, the capture stage and the
// sparse-sample renderer. The capture stage is the slave; the bench or the
// upstream/downstream glue drives the master side.
interface smpl_capture_if #(
    parameter int DATA_W = 10
);
    logic              adc_valid;
    logic [DATA_W-1:0] adc;
    logic              smpl_req;
    logic [DATA_W-1:0] smpl;
    logic              ready;
    logic              trig_auto;

    modport master (
        output adc_valid, adc, smpl_req,
        input  smpl, ready, trig_auto
    );

    modport slave (
        input  adc_valid, adc, smpl_req,
        output smpl, ready, trig_auto
    );
endinterface

// File: rtl/smpl_capture.sv
// Triggered acquisition stage: decimates the raw ADC stream into a ring
// buffer, freezes a DEPTH-sample window around a level crossing (or an
// auto-trigger timeout) with PRE samples ahead of the trigger, then streams
// the window to the renderer one sample per request and re-arms.
module smpl_capture #(
    parameter int DEPTH   = 256,
    parameter int PRE     = 32,
    parameter int TIMEOUT = 4096,
    parameter int DATA_W  = 10
) (
    input  logic              clkSmpl,
    input  logic              n_reset,
    input  logic              run,
    input  logic [15:0]       div,
    input  logic [DATA_W-1:0] level,
    input  logic              edge_sel,  // 0 = rising, 1 = falling
    input  logic              auto_en,
    smpl_capture_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_HUNT  = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_READY = 3'd4;

    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRE - 2);
    localparam logic [AW-1:0] RD_LAST   = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRE);
    localparam logic [HW-1:0] HMAX      = HW'(TIMEOUT);

    logic [2:0]        state;
    logic [15:0]       dcnt;
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic [AW-1:0]     tp;
    logic [AW-1:0]     cnt;     // keep counter shared by Pre and Post
    logic [AW-1:0]     rcnt;
    logic [HW-1:0]     hcnt;
    logic [DATA_W-1:0] prev;
    logic              trig_auto_q;
    logic [DATA_W-1:0] smpl_p1;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              acq;
    logic              keep;
    logic              rd;
    logic              crossing;
    logic              timeout_hit;
    logic [HW-1:0]     hcnt_inc;

    assign acq      = (state == S_PRE) || (state == S_HUNT) || (state == S_POST);
    assign keep     = n_reset && run && acq && bus.adc_valid && (dcnt == div);
    assign rd       = run && (state == S_READY) && bus.smpl_req;
    assign crossing = edge_sel ? ((prev > level) && (bus.adc <= level))
                               : ((prev < level) && (bus.adc >= level));
    // hcnt saturates, so reaching HMAX is the same as "at least TIMEOUT keeps"
    assign hcnt_inc    = (hcnt == HMAX) ? HMAX : hcnt + HW'(1);
    assign timeout_hit = auto_en && (hcnt_inc == HMAX);

    assign bus.smpl      = smpl_p1;
    assign bus.ready     = (state == S_READY);
    assign bus.trig_auto = trig_auto_q;

    // Decimator: count valid samples, wrap at div; held clear outside acquisition
    always_ff @(posedge clkSmpl) begin
        if (!n_reset || !run || !acq) begin
            dcnt <= '0;
        end else if (bus.adc_valid) begin
            dcnt <= (dcnt == div) ? 16'd0 : dcnt + 16'd1;
        end
    end

    // Ring buffer write of every kept sample (contents need no reset)
    always_ff @(posedge clkSmpl) begin
        if (keep) begin
            mem[wp] <= bus.adc;
        end
    end

    // Acquisition / streaming state machine with its pointers and counters
    always_ff @(posedge clkSmpl) begin
        if (!n_reset) begin
            state       <= S_IDLE;
            wp          <= '0;
            rp          <= '0;
            tp          <= '0;
            cnt         <= '0;
            rcnt        <= '0;
            hcnt        <= '0;
            prev        <= '0;
            trig_auto_q <= 1'b0;
        end else if (!run) begin
            // abort: partial frame is dropped, wp keeps its place in the ring
            state <= S_IDLE;
            rp    <= '0;
            tp    <= '0;
            cnt   <= '0;
            rcnt  <= '0;
            hcnt  <= '0;
        end else begin
            if (keep) begin
                wp   <= wp + AW'(1);
                prev <= bus.adc;
            end
            case (state)
                S_IDLE: state <= S_PRE;
                S_PRE: begin
                    if (keep) begin
                        if (cnt == PRE_LAST) begin
                            state <= S_HUNT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                end
                S_HUNT: begin
                    if (keep) begin
                        hcnt <= hcnt_inc;
                        // a real crossing wins over a simultaneous timeout
                        if (crossing || timeout_hit) begin
                            tp          <= wp;
                            trig_auto_q <= !crossing;
                            state       <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (keep) begin
                        if (cnt == POST_LAST) begin
                            state <= S_READY;
                            rp    <= tp - PRE_OFS;
                            rcnt  <= '0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                end
                S_READY: begin
                    if (bus.smpl_req) begin
                        if (rcnt == RD_LAST) begin
                            state <= S_PRE;
                            rp    <= '0;
                            tp    <= '0;
                            rcnt  <= '0;
                            hcnt  <= '0;
                            cnt   <= '0;
                        end else begin
                            rp   <= rp + AW'(1);
                            rcnt <= rcnt + AW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output register: one buffer read per accepted request, otherwise hold
    always_ff @(posedge clkSmpl) begin
        if (!n_reset) begin
            smpl_p1 <= '0;
        end else if (rd) begin
            smpl_p1 <= mem[rp];
        end
    end
endmodule

// File: tb/tb_smpl_capture.sv
// Bench for smpl_capture: directed acquisition scenarios, a queue-based frame
// model checked every cycle, a delayed-write consumer, and literal frame pins.
module tb_smpl_capture;
    localparam int DEPTH   = 16;
    localparam int PRE     = 4;
    localparam int TIMEOUT = 8;

    logic        clkSmpl = 1'b0;
    logic        n_reset;
    logic        run;
    logic [15:0] div;
    logic [9:0]  level;
    logic        edge_sel;
    logic        auto_en;

    int checks   = 0;
    int failures = 0;

    smpl_capture_if #(.DATA_W(10)) bus ();

    smpl_capture #(.DEPTH(DEPTH), .PRE(PRE), .TIMEOUT(TIMEOUT), .DATA_W(10)) dut (
        .clkSmpl (clkSmpl),
        .n_reset (n_reset),
        .run     (run),
        .div     (div),
        .level   (level),
        .edge_sel(edge_sel),
        .auto_en (auto_en),
        .bus     (bus)
    );

    always #5 clkSmpl = ~clkSmpl;

    // model: 0 idle, 1 acquiring, 2 streaming
    int ph       = 0;
    int vcnt     = 0;
    int tidx     = -1;
    int ridx     = 0;
    int n        = 0;
    int kq[$];
    int mframe[DEPTH];
    int exp_smpl = 0;
    int exp_ta   = 0;
    bit last_req = 1'b0;
    bit chk_en   = 1'b0;
    int cons[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit crosses(input int p, input int a);
        if (edge_sel) return (p > int'(level)) && (a <= int'(level));
        return (p < int'(level)) && (a >= int'(level));
    endfunction

    // Frame model: list of kept samples since arming, trigger found by rule
    always @(posedge clkSmpl) begin
        last_req = bus.smpl_req && n_reset && run;
        if (!n_reset) begin
            ph = 0; exp_smpl = 0; exp_ta = 0;
        end else if (!run) begin
            ph = 0;
        end else if (ph == 0) begin
            ph = 1; kq.delete(); vcnt = 0; tidx = -1;
        end else if (ph == 1) begin
            if (bus.adc_valid) begin
                vcnt++;
                if (vcnt % (int'(div) + 1) == 0) begin
                    kq.push_back(int'(bus.adc));
                    n = kq.size();
                    if (tidx < 0 && n > PRE) begin
                        if (crosses(kq[n-2], kq[n-1])) begin
                            tidx = n - 1; exp_ta = 0;
                        end else if (auto_en && (n - PRE >= TIMEOUT)) begin
                            tidx = n - 1; exp_ta = 1;
                        end
                    end
                    if (tidx >= 0 && n == tidx + DEPTH - PRE) begin
                        for (int k = 0; k < DEPTH; k++) mframe[k] = kq[tidx - PRE + k];
                        ph = 2; ridx = 0;
                    end
                end
            end
        end else begin
            if (bus.smpl_req) begin
                exp_smpl = mframe[ridx];
                ridx++;
                if (ridx == DEPTH) begin
                    ph = 1; kq.delete(); vcnt = 0; tidx = -1;
                end
            end
        end
    end

    // Per-cycle compare plus consumer write one cycle after each request
    always @(negedge clkSmpl) begin
        if (chk_en) begin
            chk("ready", {31'd0, bus.ready}, {31'd0, ph == 2});
            chk("smpl", {22'd0, bus.smpl}, exp_smpl);
            chk("trig_auto", {31'd0, bus.trig_auto}, exp_ta);
            if (last_req) cons.push_back(int'(bus.smpl));
        end
    end

    task automatic step();
        @(negedge clkSmpl);
    endtask

    task automatic start();
        run = 1'b1;
        bus.adc_valid = 1'b0;
        step();
    endtask

    task automatic drive_n(input int base, input int stp, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            bus.adc_valid = 1'b1;
            bus.adc = 10'((base + stp * i) & 1023);
            step();
        end
        bus.adc_valid = 1'b0;
    endtask

    task automatic acquire(input int base, input int stp);
        int i = 0;
        while (bus.ready !== 1'b1 && i < 400) begin
            bus.adc_valid = 1'b1;
            bus.adc = 10'((base + stp * i) & 1023);
            i++;
            step();
        end
        bus.adc_valid = 1'b0;
        chk("acquire_done", {31'd0, bus.ready}, 32'd1);
    endtask

    task automatic stream();
        int pat[4] = '{1, 1, 0, 1};
        int issued = 0;
        int c = 0;
        cons.delete();
        while (issued < DEPTH && c < 200) begin
            bus.smpl_req = pat[c % 4][0];
            if (pat[c % 4] != 0) issued++;
            c++;
            step();
        end
        bus.smpl_req = 1'b0;
        step();
        step();
        chk("frame_count", cons.size(), DEPTH);
        chk("ready_drop", {31'd0, bus.ready}, 32'd0);
        for (int k = 0; k < cons.size() && k < DEPTH; k++) chk("frame_model", cons[k], mframe[k]);
    endtask

    task automatic pin(input string name, input int idx, input int val);
        if (idx < cons.size()) chk(name, cons[idx], val);
        else chk(name, 32'hFFFF_FFFF, val);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_reset = 1'b0; run = 1'b0; div = 16'd0; level = 10'd512;
        edge_sel = 1'b0; auto_en = 1'b0;
        bus.adc_valid = 1'b0; bus.adc = '0; bus.smpl_req = 1'b0;
        step(); step();
        chk_en = 1'b1;
        chk("rst_ready", {31'd0, bus.ready}, 32'd0);
        chk("rst_smpl", {22'd0, bus.smpl}, 32'd0);
        chk("rst_trig_auto", {31'd0, bus.trig_auto}, 32'd0);
        n_reset = 1'b1;
        start();

        // rising ramp, trigger at 512, ring wraps on readout
        acquire(0, 64);
        chk("A_trig_auto", {31'd0, bus.trig_auto}, 32'd0);
        stream();
        pin("A_first", 0, 256); pin("A_trig", 4, 512); pin("A_last", 15, 192);

        // no crossing possible: auto-trigger on 8th Hunt keep, trigger slot 15
        level = 10'd1023; auto_en = 1'b1;
        acquire(300, 1);
        chk("B_trig_auto", {31'd0, bus.trig_auto}, 32'd1);
        stream();
        pin("B_first", 0, 307); pin("B_trig", 4, 311); pin("B_last", 15, 322);

        // keep one of every three valid samples
        auto_en = 1'b0; level = 10'd50; div = 16'd2;
        acquire(0, 1);
        stream();
        pin("C_first", 0, 38); pin("C_trig", 4, 50); pin("C_last", 15, 83);

        // flat signal holds in Hunt until auto-trigger is enabled
        div = 16'd0; level = 10'd512;
        drive_n(100, 0, 60);
        chk("D_hunt_hold", {31'd0, bus.ready}, 32'd0);
        auto_en = 1'b1;
        acquire(100, 0);
        chk("D_trig_auto", {31'd0, bus.trig_auto}, 32'd1);
        stream();
        pin("D_first", 0, 100); pin("D_last", 15, 100);

        // abort mid-Post, then a fresh frame
        auto_en = 1'b0;
        drive_n(0, 64, 12);
        run = 1'b0;
        step();
        chk("E_abort_ready", {31'd0, bus.ready}, 32'd0);
        step(); step();
        start();
        acquire(0, 64);
        stream();
        pin("E_first", 0, 256); pin("E_trig", 4, 512); pin("E_last", 15, 192);

        // reset mid-Ready, then a fresh falling-edge frame
        acquire(0, 64);
        for (int i = 0; i < 5; i++) begin
            bus.smpl_req = 1'b1;
            step();
        end
        bus.smpl_req = 1'b0;
        n_reset = 1'b0;
        step(); step();
        chk("F_rst_ready", {31'd0, bus.ready}, 32'd0);
        chk("F_rst_smpl", {22'd0, bus.smpl}, 32'd0);
        chk("F_rst_trig_auto", {31'd0, bus.trig_auto}, 32'd0);
        n_reset = 1'b1;
        edge_sel = 1'b1;
        start();
        acquire(1023, -64);
        stream();
        pin("F_first", 0, 767); pin("F_trig", 4, 511); pin("F_last", 15, 831);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/smpl_capture.md
Name: smpl_capture

Overview:
- Triggered acquisition stage on the sample clock, directly upstream of the sparse-sample renderer.
- Decimates the raw ADC stream and writes it into a DEPTH-entry ring buffer.
- Detects a level-crossing trigger (or an auto-trigger timeout) and freezes a window of DEPTH samples, PRE of them taken before the trigger.
- Streams the frozen window out one sample per cycle under the renderer's smpl_req / 1-cycle-latency protocol, then re-arms.

Parameters:
- DEPTH, 256, ring buffer entries and samples per frame; power of 2, ≥ 4.
- PRE, 32, pre-trigger samples per frame; 1 ≤ PRE < DEPTH−1.
- TIMEOUT, 4096, decimated samples spent in Hunt before an auto-trigger.

Ports:
- clkSmpl  in  1  sample clock, the only clock.
- n_reset  in  1  synchronous active-low reset.
- run  in  1  enable acquisition; 0 aborts to Idle.
- adc_valid  in  1  adc carries a new raw sample this cycle.
- adc  in  10  raw sample, unsigned.
- div  in  16  decimation: keep 1 of every div+1 valid samples.
- level  in  10  trigger level, unsigned.
- edge  in  1  0 = rising, 1 = falling.
- auto_en  in  1  enable timeout auto-trigger.
- smpl_req  in  1  consumer request; sample due the following cycle.
- smpl  out  10  registered output sample.
- ready  out  1  frame frozen and being streamed (state == Ready).
- trig_auto  out  1  last frame was auto-triggered.

Behaviour:
- Reset: all of the following take effect on a clkSmpl edge while n_reset = 0.
  - State = Idle; pointers and counters = 0.
  - smpl = 0, ready = 0, trig_auto = 0.
  - prev = 0. Buffer contents are undefined.
- Decimator:
  - dcnt counts adc_valid cycles.
  - A "keep" happens on an adc_valid cycle with dcnt == div; dcnt then resets to 0.
  - div = 0 keeps every valid sample. dcnt clears in Idle and in Ready.
- Keep actions, in Pre/Hunt/Post:
  - mem[wp] <= adc; wp <= wp+1 mod DEPTH; prev <= adc.
  - No writes in Idle or Ready.
- States:
  - Idle: run = 1 → Pre.
  - Pre: count PRE keeps, then → Hunt. The PRE-th keep is written in Pre.
  - Hunt: on each keep, evaluate the trigger on (prev, adc).
    - Rising: prev < level && adc ≥ level. Falling: prev > level && adc ≤ level.
    - The first keep in Hunt is compared against the last keep from Pre.
    - On trigger: tp <= wp (slot of the trigger sample), trig_auto <= 0, → Post.
    - If auto_en and the hcnt-th keep in Hunt reaches TIMEOUT: force a trigger on that keep, trig_auto <= 1.
    - A real crossing on that same keep takes precedence (trig_auto = 0).
  - Post: the trigger sample is written on entry. Stay for DEPTH−PRE−1 further keeps, then → Ready with rp <= tp−PRE mod DEPTH and rcnt <= 0.
  - Ready: ready = 1. On each cycle with smpl_req = 1: smpl <= mem[rp], rp++, rcnt++.
    - After the DEPTH-th read: → Pre, with pointers and counters cleared except wp. ready drops the next cycle.
- Output timing:
  - The consumer sets its write enable = smpl_req delayed 1 cycle.
  - smpl_req high at edge k loads smpl at edge k; the value is valid for the consumer's write at edge k+1. Exactly one read advance per sampled-high smpl_req.
  - Outside Ready, smpl holds its last value and the pointer does not advance.
- Frame order: streamed sample index PRE is the trigger sample. Samples are strictly in acquisition order across the ring wrap.
- run = 0 in any state → Idle next cycle. A partial frame is discarded, ready falls, smpl holds.
- Arithmetic: all pointer arithmetic is modulo DEPTH. hcnt saturates at TIMEOUT.

Test Plan:
- DEPTH=16, PRE=4, div=0, level=512, rising, ramp adc=0,64,128,… → trigger on the first keep ≥512; streamed frame = 4 samples <512 then 512… for 16 samples total; ready high until the 16th read.
- div=2, constant adc_valid → exactly every 3rd valid sample is written; frame spacing verified on a ramp of step 1.
- Flat adc=100, auto_en=1, TIMEOUT=8 → trigger on the 8th Hunt keep with trig_auto=1. With auto_en=0 → stays in Hunt indefinitely.
- smpl_req pattern 1,1,0,1 during Ready → smpl updates only on edges after high cycles; no skipped or duplicated samples; 1-cycle latency checked against a delayed-write model.
- Trigger with wp near 15 → rp wraps 15→0; order and count are correct across the wrap.
- run deasserted mid-Post, or n_reset low mid-Ready → Idle, ready=0; on re-run a full fresh frame is produced.
